// File: rtl/turbo_pkg.sv
// Shared definitions for the turbo decoder iteration scheduler.
//   turbo_state_e : scheduler FSM encoding
//   TURBO_*       : default geometry (address width, iteration width, lane width/count,
//                   decision latency, early-stop threshold)
//   SEL_DEC1/2    : siso_sel encodings (natural / interleaved half-iteration)
package turbo_pkg;

  localparam int unsigned TURBO_ADDR_W  = 10;
  localparam int unsigned TURBO_ITER_W  = 4;
  localparam int unsigned LLR_W         = 31;
  localparam int unsigned LANES         = 4;
  localparam int unsigned TURBO_DEC_LAT = 2;
  localparam int unsigned TURBO_THRESH  = 4096;

  localparam logic SEL_DEC1 = 1'b0;
  localparam logic SEL_DEC2 = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_SISO,
    ST_NEXT,
    ST_CHECK,
    ST_CHECK_WAIT,
    ST_OUTPUT,
    ST_DRAIN,
    ST_DONE
  } turbo_state_e;

endpackage

// File: rtl/turbo_addr_sweep.sv
// Word-address sweep 0..last_addr, one word per cycle, no stalls.
//   clk, rst   : clock, synchronous active-high reset
//   go         : load address 0 and start sweeping (next cycle is the first read)
//   last_addr  : final address of the sweep
//   rd_en      : registered read strobe, high for last_addr+1 cycles
//   rd_addr    : registered word address
//   last_c     : combinational, high with rd_en on the final address
module turbo_addr_sweep #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [ADDR_W-1:0] last_addr,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              last_c
);

  logic              active_q, active_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  assign last_c  = active_q && (addr_q == last_addr);
  assign rd_en   = active_q;
  assign rd_addr = addr_q;

  // Advance until the final address, then idle holding the address.
  always_comb begin
    active_d = active_q;
    addr_d   = addr_q;
    if (go) begin
      active_d = 1'b1;
      addr_d   = '0;
    end else if (active_q) begin
      if (last_c) active_d = 1'b0;
      else        addr_d   = addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      addr_q   <= '0;
    end else begin
      active_q <= active_d;
      addr_q   <= addr_d;
    end
  end

endmodule

// File: rtl/turbo_iter_ctrl.sv
// Turbo decoder iteration scheduler: alternates dec1/dec2 half-iterations up to a
// latched limit, then sweeps the LLR memory into the 4-lane hard-decision stage and
// frames its output with dec_valid/dec_last.
// Optional feature macro TURBO_EARLY_STOP_EN: after each full iteration, sweep the LLR
// memory and stop early once every lane of every word reaches THRESH confidence.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start, blk_len,       frame request; blk_len (words-1) and iter_limit latched on start
//   iter_limit
//   busy, done            frame in progress / one-cycle end-of-frame pulse
//   siso_start, siso_sel  half-iteration launch pulse and decoder select
//   siso_done             half-iteration complete
//   rd_en, rd_addr        LLR memory read port
//   llr_in                read data (early-stop check only)
//   dec_valid, dec_last   decision stream framing
//   iter_cnt, early_stop  completed iterations, convergence flag of last frame
module turbo_iter_ctrl
  import turbo_pkg::*;
#(
  parameter int unsigned ADDR_W  = TURBO_ADDR_W,
  parameter int unsigned ITER_W  = TURBO_ITER_W,
  parameter int unsigned DEC_LAT = TURBO_DEC_LAT,
  parameter int unsigned THRESH  = TURBO_THRESH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      blk_len,
  input  logic [ITER_W-1:0]      iter_limit,
  output logic                   busy,
  output logic                   done,
  output logic                   siso_start,
  output logic                   siso_sel,
  input  logic                   siso_done,
  output logic                   rd_en,
  output logic [ADDR_W-1:0]      rd_addr,
  input  logic [LANES*LLR_W-1:0] llr_in,
  output logic                   dec_valid,
  output logic                   dec_last,
  output logic [ITER_W-1:0]      iter_cnt,
  output logic                   early_stop
);

  localparam int unsigned DRAIN_W = (DEC_LAT > 1) ? $clog2(DEC_LAT) : 1;

  turbo_state_e         state_q, state_d;
  logic [ADDR_W-1:0]    len_q, len_d;
  logic [ITER_W-1:0]    limit_q, limit_d;
  logic [ITER_W-1:0]    iter_q, iter_d;
  logic [ITER_W-1:0]    iter_inc_c;
  logic                 sel_q, sel_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 sstart_q, sstart_d;
  logic [DEC_LAT-1:0]   vpipe_q, vpipe_d;
  logic [DEC_LAT-1:0]   lpipe_q, lpipe_d;
  logic                 sweep_go_c;
  logic                 sweep_last_c;
  logic                 out_phase_c;
  logic                 unused_llr_c;

  turbo_addr_sweep #(.ADDR_W(ADDR_W)) u_sweep (
    .clk       (clk),
    .rst       (rst),
    .go        (sweep_go_c),
    .last_addr (len_q),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .last_c    (sweep_last_c)
  );

  assign busy       = busy_q;
  assign done       = done_q;
  assign siso_start = sstart_q;
  assign siso_sel   = sel_q;
  assign iter_cnt   = iter_q;
  assign dec_valid  = vpipe_q[DEC_LAT-1];
  assign dec_last   = lpipe_q[DEC_LAT-1];

  // Saturating increment of the completed-iteration count.
  assign iter_inc_c = (iter_q == '1) ? iter_q : iter_q + ITER_W'(1);

  // Only the OUTPUT sweep feeds the decision stage; CHECK reads are not framed.
  assign out_phase_c = (state_q == ST_OUTPUT);

`ifdef TURBO_EARLY_STOP_EN
  logic conv_q, conv_d;
  logic chk_vld_q, chk_vld_d;
  logic early_q, early_d;
  logic lanes_ok_c;

  assign early_stop   = early_q;
  assign unused_llr_c = ^llr_in;
  assign chk_vld_d    = rd_en && (state_q == ST_CHECK);

  // All four lanes of the current read word meet the confidence threshold (sign ignored).
  always_comb begin
    lanes_ok_c = 1'b1;
    for (int i = 0; i < int'(LANES); i++) begin
      if (llr_in[i*LLR_W +: (LLR_W-1)] < (LLR_W-1)'(THRESH)) lanes_ok_c = 1'b0;
    end
  end
`else
  assign early_stop   = 1'b0;
  assign unused_llr_c = ^{llr_in, 32'(THRESH)};
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    limit_d    = limit_q;
    iter_d     = iter_q;
    sel_d      = sel_q;
    drain_d    = drain_q;
    sweep_go_c = 1'b0;
`ifdef TURBO_EARLY_STOP_EN
    conv_d     = conv_q;
    early_d    = early_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LAUNCH;
          len_d   = blk_len;
          limit_d = (iter_limit == '0) ? ITER_W'(1) : iter_limit;
          iter_d  = '0;
          sel_d   = SEL_DEC1;
`ifdef TURBO_EARLY_STOP_EN
          early_d = 1'b0;
`endif
        end
      end
      ST_LAUNCH:    state_d = ST_WAIT_SISO;
      ST_WAIT_SISO: if (siso_done) state_d = ST_NEXT;
      ST_NEXT: begin
        if (sel_q == SEL_DEC1) begin
          sel_d   = SEL_DEC2;
          state_d = ST_LAUNCH;
        end else begin
          sel_d  = SEL_DEC1;
          iter_d = iter_inc_c;
          if (iter_inc_c == limit_q) begin
            state_d    = ST_OUTPUT;
            sweep_go_c = 1'b1;
          end else begin
`ifdef TURBO_EARLY_STOP_EN
            state_d    = ST_CHECK;
            sweep_go_c = 1'b1;
            conv_d     = 1'b1;
`else
            state_d    = ST_LAUNCH;
`endif
          end
        end
      end
`ifdef TURBO_EARLY_STOP_EN
      // Data trails rd_en by one cycle; fold each arriving word into the verdict.
      ST_CHECK: begin
        if (chk_vld_q) conv_d = conv_q & lanes_ok_c;
        if (sweep_last_c) state_d = ST_CHECK_WAIT;
      end
      // Final word arrives here; decide without registering it first.
      ST_CHECK_WAIT: begin
        if (conv_q && lanes_ok_c) begin
          state_d    = ST_OUTPUT;
          sweep_go_c = 1'b1;
          early_d    = 1'b1;
        end else begin
          state_d = ST_LAUNCH;
        end
      end
`endif
      ST_OUTPUT: begin
        if (sweep_last_c) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end
      end
      ST_DRAIN: begin
        if (drain_q == DRAIN_W'(DEC_LAT - 1)) state_d = ST_DONE;
        else                                  drain_d = drain_q + DRAIN_W'(1);
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d   = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d   = (state_d == ST_DONE);
    sstart_d = (state_d == ST_LAUNCH);

    vpipe_d[0] = rd_en && out_phase_c;
    lpipe_d[0] = sweep_last_c && out_phase_c;
    for (int i = 1; i < int'(DEC_LAT); i++) begin
      vpipe_d[i] = vpipe_q[i-1];
      lpipe_d[i] = lpipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      limit_q  <= '0;
      iter_q   <= '0;
      sel_q    <= SEL_DEC1;
      drain_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sstart_q <= 1'b0;
      vpipe_q  <= '0;
      lpipe_q  <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      limit_q  <= limit_d;
      iter_q   <= iter_d;
      sel_q    <= sel_d;
      drain_q  <= drain_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sstart_q <= sstart_d;
      vpipe_q  <= vpipe_d;
      lpipe_q  <= lpipe_d;
    end
  end

`ifdef TURBO_EARLY_STOP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      conv_q    <= 1'b0;
      chk_vld_q <= 1'b0;
      early_q   <= 1'b0;
    end else begin
      conv_q    <= conv_d;
      chk_vld_q <= chk_vld_d;
      early_q   <= early_d;
    end
  end
`endif

endmodule

// File: tb/tb_turbo_iter_ctrl.sv
// Directed testbench for turbo_iter_ctrl: runs whole frames against a simple SISO
// responder, collects per-frame event counts and compares them with hand-derived values.
module tb_turbo_iter_ctrl;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned ITER_W = 4;
  localparam int unsigned LLR_W  = 31;

  logic                 clk;
  logic                 rst;
  logic                 start;
  logic [ADDR_W-1:0]    blk_len;
  logic [ITER_W-1:0]    iter_limit;
  logic                 busy, done, siso_start, siso_sel;
  logic                 siso_done;
  logic                 rd_en;
  logic [ADDR_W-1:0]    rd_addr;
  logic [4*LLR_W-1:0]   llr_in;
  logic                 dec_valid, dec_last;
  logic [ITER_W-1:0]    iter_cnt;
  logic                 early_stop;

  turbo_iter_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .blk_len    (blk_len),
    .iter_limit (iter_limit),
    .busy       (busy),
    .done       (done),
    .siso_start (siso_start),
    .siso_sel   (siso_sel),
    .siso_done  (siso_done),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .llr_in     (llr_in),
    .dec_valid  (dec_valid),
    .dec_last   (dec_last),
    .iter_cnt   (iter_cnt),
    .early_stop (early_stop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  // Per-frame statistics gathered by run_frame.
  int          n_start, n_valid, n_last, last_pos, n_orphan, n_rd, n_done, n_busy_done;
  int          last_rd, done_c, timed_out;
  logic [15:0] sel_hist;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Runs one frame; the SISO responder answers each siso_start dly cycles later.
  // inject: spurious siso_done with the first pulse and a start during WAIT_SISO.
  // abort_at >= 0: assert rst while rd_en is high on that read and check the flush.
  task automatic run_frame(input int len, input int lim, input int dly,
                           input bit inject, input int abort_at);
    int tmr, post, abort_c;
    bit injected, aborted;
    n_start = 0; n_valid = 0; n_last = 0; last_pos = 0; n_orphan = 0; n_rd = 0;
    n_done = 0; n_busy_done = 0; last_rd = -1; done_c = -1; timed_out = 1;
    sel_hist = '0; tmr = 0; post = 0; abort_c = -1; injected = 1'b0; aborted = 1'b0;
    @(negedge clk);
    blk_len = ADDR_W'(len); iter_limit = ITER_W'(lim); start = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      start = 1'b0; rst = 1'b0; siso_done = 1'b0;
      blk_len = ADDR_W'(5); iter_limit = ITER_W'(2);
      if (siso_start) begin n_start++; sel_hist = {sel_hist[14:0], siso_sel}; end
      if (dec_valid) begin
        n_valid++;
        if (dec_last) begin n_last++; last_pos = n_valid; end
      end
      if (dec_last && !dec_valid) n_orphan++;
      if (rd_en) begin n_rd++; last_rd = c; end
      if (done) begin n_done++; done_c = c; if (busy) n_busy_done++; end
      if (tmr > 0) begin tmr--; if (tmr == 0) siso_done = 1'b1; end
      if (siso_start) begin
        tmr = dly;
        if (inject && n_start == 1) siso_done = 1'b1;
      end
      if (inject && !injected && busy && tmr == 3) begin
        start = 1'b1; blk_len = '0; iter_limit = ITER_W'(1); injected = 1'b1;
      end
      if (aborted && c == abort_c + 1) begin
        check_eq("abort_busy", int'(busy), 0);
        check_eq("abort_dec_valid", int'(dec_valid), 0);
        check_eq("abort_rd_en", int'(rd_en), 0);
        check_eq("abort_iter_cnt", int'(iter_cnt), 0);
      end
      if (aborted && c == abort_c + 8) begin timed_out = 0; break; end
      if (abort_at >= 0 && !aborted && rd_en && n_rd == abort_at) begin
        rst = 1'b1; aborted = 1'b1; abort_c = c;
      end
      if (n_done > 0) post++;
      if (post >= 4) begin timed_out = 0; break; end
    end
    if (timed_out != 0) check_eq("frame_timeout", timed_out, 0);
  endtask

  logic [LLR_W-1:0] lane_hi, lane_lo;

  initial begin
    rst = 1'b1; start = 1'b0; blk_len = '0; iter_limit = '0; siso_done = 1'b0; llr_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_siso_start", int'(siso_start), 0);
    check_eq("rst_sel", int'(siso_sel), 0);
    check_eq("rst_rd", int'({rd_en, rd_addr}), 0);
    check_eq("rst_dec", int'({dec_valid, dec_last}), 0);
    check_eq("rst_iter_cnt", int'(iter_cnt), 0);
    check_eq("rst_early_stop", int'(early_stop), 0);

    // 1: limit 3, eight words
    run_frame(7, 3, 5, 1'b0, -1);
    check_eq("t1_pulses", n_start, 6);
    check_eq("t1_sel_seq", int'(sel_hist[5:0]), 6'b010101);
    check_eq("t1_valid", n_valid, 8);
    check_eq("t1_last_cnt", n_last, 1);
    check_eq("t1_last_pos", last_pos, 8);
    check_eq("t1_orphan_last", n_orphan, 0);
    check_eq("t1_done", n_done, 1);
    check_eq("t1_busy_at_done", n_busy_done, 0);
    check_eq("t1_iter_cnt", int'(iter_cnt), 3);
    check_eq("t1_busy_after", int'(busy), 0);
    check_eq("t1_early_stop", int'(early_stop), 0);
`ifdef TURBO_EARLY_STOP_EN
    check_eq("t1_reads", n_rd, 24);
`else
    check_eq("t1_reads", n_rd, 8);
`endif

    // 2: limit 0 behaves as 1
    run_frame(3, 0, 2, 1'b0, -1);
    check_eq("t2_pulses", n_start, 2);
    check_eq("t2_iter_cnt", int'(iter_cnt), 1);
    check_eq("t2_valid", n_valid, 4);

    // 3: single-word frame
    run_frame(0, 1, 1, 1'b0, -1);
    check_eq("t3_valid", n_valid, 1);
    check_eq("t3_last", n_last, 1);
    check_eq("t3_last_pos", last_pos, 1);
    check_eq("t3_done_lat", done_c - last_rd, 3);

    // 4: spurious siso_done in IDLE, then start/siso_done noise inside a frame
    @(negedge clk); siso_done = 1'b1;
    @(negedge clk); siso_done = 1'b0;
    @(negedge clk);
    check_eq("t4_idle_busy", int'(busy), 0);
    check_eq("t4_idle_pulse", int'(siso_start), 0);
    run_frame(4, 2, 5, 1'b1, -1);
    check_eq("t4_pulses", n_start, 4);
    check_eq("t4_sel_seq", int'(sel_hist[3:0]), 4'b0101);
    check_eq("t4_valid", n_valid, 5);
    check_eq("t4_done", n_done, 1);
    check_eq("t4_iter_cnt", int'(iter_cnt), 2);

    // 5: reset in the middle of the output sweep, then a fresh frame
    run_frame(15, 1, 2, 1'b0, 3);
    check_eq("t5_abort_done", n_done, 0);
    run_frame(2, 1, 2, 1'b0, -1);
    check_eq("t5_valid", n_valid, 3);
    check_eq("t5_last_pos", last_pos, 3);
    check_eq("t5_done", n_done, 1);

`ifdef TURBO_EARLY_STOP_EN
    // 6: converged memory stops after one iteration; one weak lane forces all eight
    lane_hi = {1'b1, 30'd5000};
    lane_lo = {1'b0, 30'd100};
    llr_in = {lane_hi, lane_hi, lane_hi, lane_hi};
    run_frame(3, 8, 2, 1'b0, -1);
    check_eq("t6_conv_pulses", n_start, 2);
    check_eq("t6_conv_iter", int'(iter_cnt), 1);
    check_eq("t6_conv_early", int'(early_stop), 1);
    check_eq("t6_conv_valid", n_valid, 4);
    llr_in = {lane_hi, lane_lo, lane_hi, lane_hi};
    run_frame(3, 8, 2, 1'b0, -1);
    check_eq("t6_weak_pulses", n_start, 16);
    check_eq("t6_weak_iter", int'(iter_cnt), 8);
    check_eq("t6_weak_early", int'(early_stop), 0);
    check_eq("t6_weak_valid", n_valid, 4);
`else
    lane_hi = '0;
    lane_lo = '0;
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
